// File: rtl/lzrw1_pkg.sv
// rtl/lzrw1_pkg.sv - shared types and constants for the LZRW1 stream unpacker
package lzrw1_pkg;

  typedef enum logic [2:0] {
    S_CW,
    S_B0,
    S_B1,
    S_OUT,
    S_DONE,
    S_ERR
  } unpack_state_t;

  localparam int ITEM_W       = 16;
  localparam logic FLAG_LITERAL = 1'b0;
  localparam logic FLAG_COPY    = 1'b1;
  localparam int FLAGS_PER_CW = 8;

endpackage

// File: rtl/lzrw1_cw_shifter.sv
// rtl/lzrw1_cw_shifter.sv - control-word flag shift register with flags-used counter
module lzrw1_cw_shifter
  import lzrw1_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [FLAGS_PER_CW-1:0] cw_i,
  input  logic                    shift_i,
  output logic                    flag_o,
  output logic                    cw_exhausted_o
);

  localparam int CNT_W = $clog2(FLAGS_PER_CW);

  logic [FLAGS_PER_CW-1:0] flags_q;
  logic [CNT_W-1:0]        used_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      used_q  <= '0;
    end else if (load_i) begin
      flags_q <= cw_i;
      used_q  <= '0;
    end else if (shift_i) begin
      flags_q <= {flags_q[FLAGS_PER_CW-2:0], 1'b0};
      used_q  <= used_q + CNT_W'(1);
    end
  end

  assign flag_o = flags_q[FLAGS_PER_CW-1];
  // True while the last flag of the byte is current, i.e. this shift uses it up.
  assign cw_exhausted_o = (used_q == CNT_W'(FLAGS_PER_CW - 1));

endmodule

// File: rtl/lzrw1_stream_unpacker.sv
// rtl/lzrw1_stream_unpacker.sv - splits LZRW1 byte/control streams into 16-bit items
module lzrw1_stream_unpacker
  import lzrw1_pkg::*;
#(
  parameter int ITEM_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_in_valid,
  input  logic                        byte_in_last,
  output logic                        byte_in_ready,
  input  logic [7:0]                  cw_in,
  input  logic                        cw_in_valid,
  output logic                        cw_in_ready,
  output logic [ITEM_W-1:0]           data_out,
  output logic                        control_word_out,
  output logic                        data_out_valid,
  input  logic                        decompressor_busy,
  output logic                        stream_done,
  output logic                        format_error,
  output logic [ITEM_COUNT_WIDTH-1:0] items_emitted
);

  unpack_state_t               state_q;
  logic [7:0]                  b0_q;
  logic                        last_q;
  logic [ITEM_W-1:0]           data_q;
  logic                        ctrl_q;
  logic                        err_q;
  logic [ITEM_COUNT_WIDTH-1:0] items_q;

  logic cur_flag;
  logic cw_exhausted;
  logic cw_load;
  logic item_xfer;

  assign cw_load   = (state_q == S_CW) && cw_in_valid;
  assign item_xfer = (state_q == S_OUT) && !decompressor_busy;

  lzrw1_cw_shifter u_cw_shifter (
    .clock          (clock),
    .reset          (reset),
    .load_i         (cw_load),
    .cw_i           (cw_in),
    .shift_i        (item_xfer),
    .flag_o         (cur_flag),
    .cw_exhausted_o (cw_exhausted)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_CW;
      b0_q    <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= FLAG_LITERAL;
      err_q   <= 1'b0;
      items_q <= '0;
    end else begin
      case (state_q)
        S_CW: begin
          if (cw_in_valid) state_q <= S_B0;
        end
        S_B0: begin
          if (byte_in_valid) begin
            b0_q   <= byte_in;
            last_q <= byte_in_last;
            if (cur_flag == FLAG_LITERAL) begin
              data_q  <= {8'h00, byte_in};
              ctrl_q  <= FLAG_LITERAL;
              state_q <= S_OUT;
            end else if (!byte_in_last) begin
              state_q <= S_B1;
            end else begin
              // A copy needs two bytes; the stream ended after one.
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_B1: begin
          if (byte_in_valid) begin
            data_q  <= {b0_q, byte_in};
            ctrl_q  <= FLAG_COPY;
            last_q  <= byte_in_last;
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (!decompressor_busy) begin
            items_q <= items_q + ITEM_COUNT_WIDTH'(1);
            if (last_q)            state_q <= S_DONE;
            else if (cw_exhausted) state_q <= S_CW;
            else                   state_q <= S_B0;
          end
        end
        S_DONE: begin
          items_q <= '0;
          state_q <= S_CW;
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_CW;
      endcase
    end
  end

  assign cw_in_ready      = (state_q == S_CW);
  assign byte_in_ready    = (state_q == S_B0) || (state_q == S_B1);
  assign data_out_valid   = (state_q == S_OUT);
  assign stream_done      = (state_q == S_DONE);
  assign data_out         = data_q;
  assign control_word_out = ctrl_q;
  assign format_error     = err_q;
  assign items_emitted    = items_q;

endmodule

// File: tb/tb_lzrw1_stream_unpacker.sv
// tb/tb_lzrw1_stream_unpacker.sv - randomized self-checking bench for lzrw1_stream_unpacker
module tb_lzrw1_stream_unpacker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_last = 1'b0;
  logic        byte_in_ready;
  logic [7:0]  cw_in = '0;
  logic        cw_in_valid = 1'b0;
  logic        cw_in_ready;
  logic [15:0] data_out;
  logic        control_word_out;
  logic        data_out_valid;
  logic        decompressor_busy = 1'b0;
  logic        stream_done;
  logic        format_error;
  logic [15:0] items_emitted;

  always #5 clock = ~clock;

  lzrw1_stream_unpacker #(.ITEM_COUNT_WIDTH(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_in_last      (byte_in_last),
    .byte_in_ready     (byte_in_ready),
    .cw_in             (cw_in),
    .cw_in_valid       (cw_in_valid),
    .cw_in_ready       (cw_in_ready),
    .data_out          (data_out),
    .control_word_out  (control_word_out),
    .data_out_valid    (data_out_valid),
    .decompressor_busy (decompressor_busy),
    .stream_done       (stream_done),
    .format_error      (format_error),
    .items_emitted     (items_emitted)
  );

  typedef struct {logic [7:0] data; logic last; logic ends_item;} byte_t;
  typedef struct {logic [15:0] data; logic ctrl;} item_t;

  byte_t       byte_q[$];
  logic [7:0]  cw_q[$];
  item_t       exp_q[$];
  int          stream_q[$];

  int          total = 0;
  int          bad = 0;
  int          in_pct = 100;
  int          busy_pct = 0;
  int          hold_req = 0;
  logic [15:0] run_cnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one item is one literal byte or two copy bytes; flags MSB-first.
  task automatic push_item(input logic flag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic last);
    item_t it;
    if (!flag) begin
      byte_q.push_back('{data: b0, last: last, ends_item: 1'b1});
      it.data = {8'h00, b0};
    end else begin
      byte_q.push_back('{data: b0, last: 1'b0, ends_item: 1'b0});
      byte_q.push_back('{data: b1, last: last, ends_item: 1'b1});
      it.data = {b0, b1};
    end
    it.ctrl = flag;
    exp_q.push_back(it);
  endtask

  task automatic gen_stream(input int n, input int copy_pct);
    logic [7:0] cw;
    logic       flag;
    cw = '0;
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 0) cw = 8'($urandom);
      flag = ($urandom_range(99) < copy_pct);
      cw[7 - (i % 8)] = flag;
      if ((i % 8 == 7) || (i == n - 1)) cw_q.push_back(cw);
      push_item(flag, 8'($urandom), 8'($urandom), i == n - 1);
    end
    stream_q.push_back(n);
  endtask

  // Per-cycle driver and monitor, all activity on the falling edge.
  initial begin
    bit b_pend, c_pend, x_prev, d_prev, item_ready;
    item_t it;
    b_pend = 0; c_pend = 0; x_prev = 0; d_prev = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        b_pend = 0; c_pend = 0; x_prev = 0; d_prev = 0;
        byte_in_valid = 0; cw_in_valid = 0; byte_in_last = 0; decompressor_busy = 0;
      end else begin
        item_ready = 0;
        if (b_pend && byte_q.size() > 0) begin
          item_ready = byte_q[0].ends_item;
          void'(byte_q.pop_front());
        end
        if (c_pend && cw_q.size() > 0) void'(cw_q.pop_front());
        if (item_ready) check_eq("latency_valid", data_out_valid, 1);
        if (x_prev) check_eq("no_repeat", data_out_valid, 0);
        if (d_prev) check_eq("done_one_cycle", stream_done, 0);
        check_eq("items_emitted", items_emitted, run_cnt);
        check_eq("ready_exclusive", byte_in_ready & cw_in_ready, 0);
        if (cw_in_ready) check_eq("cw_boundary", run_cnt[2:0], 0);
        if (stream_done) begin
          if (stream_q.size() > 0) check_eq("stream_len", run_cnt, stream_q.pop_front());
          else check_eq("spurious_done", stream_done, 0);
          run_cnt = '0;
        end
        d_prev = stream_done;

        byte_in_valid = (byte_q.size() > 0) && ($urandom_range(99) < in_pct);
        byte_in       = byte_in_valid ? byte_q[0].data : 8'($urandom);
        byte_in_last  = byte_in_valid ? byte_q[0].last : 1'b0;
        cw_in_valid   = (cw_q.size() > 0) && ($urandom_range(99) < in_pct);
        cw_in         = cw_in_valid ? cw_q[0] : 8'($urandom);

        if (hold_req > 0 && data_out_valid) begin
          decompressor_busy = 1;
          hold_req--;
          if (exp_q.size() > 0) check_eq("hold_data", data_out, exp_q[0].data);
        end else begin
          decompressor_busy = ($urandom_range(99) < busy_pct);
        end

        b_pend = byte_in_valid && byte_in_ready;
        c_pend = cw_in_valid && cw_in_ready;
        x_prev = data_out_valid && !decompressor_busy;
        if (x_prev) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_item", data_out_valid, 0);
          end else begin
            it = exp_q.pop_front();
            check_eq("item_data", data_out, it.data);
            check_eq("item_flag", control_word_out, it.ctrl);
          end
          run_cnt = run_cnt + 16'd1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 0;
    byte_q.delete(); cw_q.delete(); exp_q.delete(); stream_q.delete();
    run_cnt = '0; hold_req = 0;
    @(posedge clock); #1;
    check_eq("rst_valid", data_out_valid, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_flag", control_word_out, 0);
    check_eq("rst_byte_ready", byte_in_ready, 0);
    check_eq("rst_cw_ready", cw_in_ready, 1);
    check_eq("rst_done", stream_done, 0);
    check_eq("rst_format_error", format_error, 0);
    check_eq("rst_items", items_emitted, 0);
    reset = 1;
    repeat (3) @(posedge clock); #1;
    check_eq("post_rst_valid", data_out_valid, 0);
    check_eq("post_rst_cw_ready", cw_in_ready, 1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || stream_q.size() > 0 || byte_q.size() > 0 || cw_q.size() > 0)
           && c < budget) begin
      @(posedge clock);
      c++;
    end
    check_eq("idle_timeout", c < budget, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int c;
    do_reset();

    // Three literals
    cw_q.push_back(8'h00);
    push_item(0, 8'h41, 8'h00, 0);
    push_item(0, 8'h42, 8'h00, 0);
    push_item(0, 8'h43, 8'h00, 1);
    stream_q.push_back(3);
    wait_idle(200);

    // Literal then copy
    cw_q.push_back(8'h40);
    push_item(0, 8'h61, 8'h00, 0);
    push_item(1, 8'h10, 8'h03, 1);
    stream_q.push_back(2);
    wait_idle(200);

    // Back-pressure for five cycles on one item
    hold_req = 5;
    cw_q.push_back(8'h00);
    push_item(0, 8'h5A, 8'h00, 1);
    stream_q.push_back(1);
    wait_idle(200);
    check_eq("hold_consumed", hold_req, 0);

    // Nine literals span two control-word bytes
    cw_q.push_back(8'h00);
    cw_q.push_back(8'h00);
    for (int i = 0; i < 9; i++) push_item(0, 8'(8'h30 + i), 8'h00, i == 8);
    stream_q.push_back(9);
    wait_idle(400);

    // Randomized streams with stalls on both sides
    in_pct = 70; busy_pct = 30;
    for (int s = 0; s < 20; s++) gen_stream($urandom_range(1, 20), 50);
    wait_idle(20000);
    check_eq("no_format_error", format_error, 0);
    in_pct = 100; busy_pct = 0;

    // Reset in the middle of a copy item
    cw_q.push_back(8'h80);
    byte_q.push_back('{data: 8'h55, last: 1'b0, ends_item: 1'b0});
    c = 0;
    while (byte_q.size() > 0 && c < 100) begin @(posedge clock); c++; end
    check_eq("midcopy_timeout", c < 100, 1);
    repeat (2) @(posedge clock); #1;
    check_eq("midcopy_no_item", data_out_valid, 0);
    do_reset();
    repeat (5) @(posedge clock); #1;
    check_eq("after_midcopy_valid", data_out_valid, 0);

    // Truncated copy: the stream ends after the first copy byte
    cw_q.push_back(8'h80);
    byte_q.push_back('{data: 8'h77, last: 1'b1, ends_item: 1'b0});
    c = 0;
    while (byte_q.size() > 0 && c < 100) begin @(posedge clock); c++; end
    check_eq("trunc_timeout", c < 100, 1);
    repeat (6) @(posedge clock); #1;
    check_eq("trunc_format_error", format_error, 1);
    check_eq("trunc_byte_ready", byte_in_ready, 0);
    check_eq("trunc_cw_ready", cw_in_ready, 0);
    check_eq("trunc_valid", data_out_valid, 0);
    check_eq("trunc_items", items_emitted, 0);
    do_reset();

    // Recovery after the error
    cw_q.push_back(8'h20);
    push_item(0, 8'h01, 8'h00, 0);
    push_item(0, 8'h02, 8'h00, 0);
    push_item(1, 8'hAB, 8'hCD, 1);
    stream_q.push_back(3);
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
